// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-FIFO bridge: FSM states, word HSIZE and packet field positions.
package bridge_pkg;

  typedef enum logic [2:0] {IDLE, DATA, PUSH, WAIT_RSP, ERR1, ERR2, SLEEP} src_state_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Request packet, LSB first: data, addr, valid marker, rd0_wr1.
  localparam int PKT_DATA_LSB = 0;

  function automatic int pkt_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int pkt_valid_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int pkt_wr_bit(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/source_controller.sv
// AHB slave front end turning word transfers into request packets and matching responses; SRC_POSTED_WRITE_EN enables posted writes.
// Latency: address phase N, push N+2, pop >= N+3, hreadyout one cycle after the pop (posted write: one cycle after push).
// Backpressure: holds in PUSH while i_req_full, waits in WAIT_RSP while i_rsp_empty; AHB stalled via o_hreadyout=0.
module source_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int P_SIZE     = 3
) (
  input  logic                           i_clk_source,
  input  logic                           i_rst_source,
  input  logic                           i_hsel,
  input  logic [1:0]                     i_htrans,
  input  logic                           i_hwrite,
  input  logic [2:0]                     i_hsize,
  input  logic [ADDR_WIDTH-1:0]          i_haddr,
  input  logic [DATA_WIDTH-1:0]          i_hwdata,
  output logic                           o_hreadyout,
  output logic                           o_hresp,
  output logic [DATA_WIDTH-1:0]          o_hrdata,
  input  logic                           i_req_full,
  output logic                           o_req_wr_en,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] o_req_packet,
  input  logic                           i_rsp_empty,
  input  logic [DATA_WIDTH:0]            i_rsp_packet,
  output logic                           o_rsp_rd_en,
  input  logic                           i_source_sleep_req,
  output logic                           o_source_sleep_ack,
  output logic                           o_source_sleep_status,
  input  logic                           i_sink_sleep_status
);

  localparam int PKT_W    = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int WR_BIT   = pkt_wr_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int VLD_BIT  = pkt_valid_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int ADDR_LSB = pkt_addr_lsb(DATA_WIDTH);
  localparam logic [P_SIZE-1:0] CNT_MAX = '1;

`ifdef SRC_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  src_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [PKT_W-1:0]        pkt_q, pkt_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    sleep_err_q, sleep_err_d;
  logic [P_SIZE-1:0]       cnt_q;
  logic                    hready, accept, bad_xfer;
  logic                    push, posted_push, pop_own, pop_discard;
  logic                    unused_htrans0;

  assign unused_htrans0 = i_htrans[0];

  assign hready   = (state_q == IDLE) || (state_q == SLEEP) || (state_q == ERR2);
  assign accept   = i_hsel & i_htrans[1] & hready;
  assign bad_xfer = (i_hsize != HSIZE_WORD) || (i_haddr[1:0] != 2'b00);

  // A posted write may not push once the counter would overflow.
  assign push        = (state_q == PUSH) && !i_req_full && !i_rst_source &&
                       !(POSTED && write_q && (cnt_q == CNT_MAX));
  assign posted_push = push && POSTED && write_q;
  assign pop_discard = (cnt_q != '0) && !i_rsp_empty && !i_rst_source;
  assign pop_own     = (state_q == WAIT_RSP) && (cnt_q == '0) && !i_rsp_empty && !i_rst_source;

  always_comb begin
    state_d     = state_q;
    sleep_err_d = sleep_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = bad_xfer ? ERR1 : DATA;
          sleep_err_d = 1'b0;
        end else if (i_source_sleep_req && (cnt_q == '0)) begin
          state_d = SLEEP;
        end
      end
      DATA:     state_d = PUSH;
      PUSH:     if (push) state_d = posted_push ? IDLE : WAIT_RSP;
      WAIT_RSP: if (pop_own) state_d = i_rsp_packet[DATA_WIDTH] ? ERR1 : IDLE;
      ERR1:     state_d = ERR2;
      ERR2: begin
        if (accept) state_d = (sleep_err_q || bad_xfer) ? ERR1 : DATA;
        else        state_d = sleep_err_q ? SLEEP : IDLE;
      end
      SLEEP: begin
        if (accept) begin
          state_d     = ERR1;
          sleep_err_d = 1'b1;
        end else if (!i_source_sleep_req && !i_sink_sleep_status) begin
          state_d     = IDLE;
          sleep_err_d = 1'b0;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_d                                = '0;
    pkt_d[WR_BIT]                        = write_q;
    pkt_d[VLD_BIT]                       = 1'b1;
    pkt_d[ADDR_LSB +: ADDR_WIDTH]        = addr_q;
    pkt_d[PKT_DATA_LSB +: DATA_WIDTH]    = write_q ? i_hwdata : '0;
  end

  always_ff @(posedge i_clk_source) begin
    if (i_rst_source) begin
      state_q     <= IDLE;
      sleep_err_q <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      pkt_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sleep_err_q <= sleep_err_d;
      if (accept) begin
        addr_q  <= i_haddr;
        write_q <= i_hwrite;
      end
      if (state_q == DATA) pkt_q <= pkt_d;
      if (pop_own) rdata_q <= i_rsp_packet[DATA_WIDTH-1:0];
    end
  end

`ifdef SRC_POSTED_WRITE_EN
  always_ff @(posedge i_clk_source) begin
    if (i_rst_source) begin
      cnt_q <= '0;
    end else begin
      case ({posted_push, pop_discard})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
`else
  assign cnt_q = '0;
`endif

  // Errors raised while asleep keep the sleep indication up.
  assign o_source_sleep_status = (state_q == SLEEP) ||
                                 (((state_q == ERR1) || (state_q == ERR2)) && sleep_err_q);
  assign o_source_sleep_ack    = o_source_sleep_status;
  assign o_hreadyout           = hready;
  assign o_hresp               = (state_q == ERR1) || (state_q == ERR2);
  assign o_hrdata              = rdata_q;
  assign o_req_wr_en           = push;
  assign o_req_packet          = pkt_q;
  assign o_rsp_rd_en           = pop_own || pop_discard;

endmodule

// File: tb/tb_source_controller.sv
// Bench for source_controller: emulates both FIFOs and checks transfers against a per-transfer outcome model.
module tb_source_controller;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = AW + DW + 2;
`ifdef SRC_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_hsel, i_hwrite, i_req_full, i_rsp_empty;
  logic [1:0]    i_htrans;
  logic [2:0]    i_hsize;
  logic [AW-1:0] i_haddr;
  logic [DW-1:0] i_hwdata;
  logic [DW:0]   i_rsp_packet;
  logic          i_source_sleep_req, i_sink_sleep_status;
  logic          o_hreadyout, o_hresp, o_req_wr_en, o_rsp_rd_en;
  logic          o_source_sleep_ack, o_source_sleep_status;
  logic [DW-1:0] o_hrdata;
  logic [PW-1:0] o_req_packet;

  typedef struct { logic err; logic [DW-1:0] data; int avail; } rsp_t;
  rsp_t rsp_q[$];
  int   cyc, checks, errors;

  int            r_ready_k, r_pushes, r_pops;
  logic          r_resp, r_err_pre, r_timeout;
  logic [DW-1:0] r_rdata;
  logic [PW-1:0] r_pkt;

  always #5 clk = ~clk;

  source_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .P_SIZE(3)) dut (
    .i_clk_source(clk), .i_rst_source(rst),
    .i_hsel(i_hsel), .i_htrans(i_htrans), .i_hwrite(i_hwrite), .i_hsize(i_hsize),
    .i_haddr(i_haddr), .i_hwdata(i_hwdata),
    .o_hreadyout(o_hreadyout), .o_hresp(o_hresp), .o_hrdata(o_hrdata),
    .i_req_full(i_req_full), .o_req_wr_en(o_req_wr_en), .o_req_packet(o_req_packet),
    .i_rsp_empty(i_rsp_empty), .i_rsp_packet(i_rsp_packet), .o_rsp_rd_en(o_rsp_rd_en),
    .i_source_sleep_req(i_source_sleep_req), .o_source_sleep_ack(o_source_sleep_ack),
    .o_source_sleep_status(o_source_sleep_status), .i_sink_sleep_status(i_sink_sleep_status)
  );

  function automatic logic [PW-1:0] exp_pkt(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {wr, 1'b1, a, (wr ? d : {DW{1'b0}})};
  endfunction

  task automatic drive_fifos(input int k, input int full_n);
    i_req_full   = (k < full_n);
    i_rsp_empty  = !(rsp_q.size() > 0 && rsp_q[0].avail <= cyc);
    i_rsp_packet = (rsp_q.size() > 0) ? {rsp_q[0].err, rsp_q[0].data} : '0;
  endtask

  task automatic idle_cycles(input int n);
    rsp_t tmp;
    for (int i = 0; i < n; i++) begin
      drive_fifos(0, 0);
      #4;
      if (o_rsp_rd_en && !i_rsp_empty) tmp = rsp_q.pop_front();
      cyc++;
      @(posedge clk); #1;
    end
    i_rsp_empty = 1'b1;
  endtask

  // One AHB transfer; the FIFO side answers each push with (rerr, rdat) after 'delay' cycles.
  task automatic ahb_xfer(input logic wr, input logic [2:0] size, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic rerr, input logic [DW-1:0] rdat,
                          input int full_n, input int delay, input bit no_rsp);
    rsp_t tmp;
    logic prev;
    r_pushes = 0; r_pops = 0; r_pkt = '0; r_timeout = 1'b1; r_ready_k = -1;
    r_resp = 1'b0; r_err_pre = 1'b0; r_rdata = '0; prev = 1'b0;
    i_hsel = 1'b1; i_htrans = 2'b10; i_hwrite = wr; i_hsize = size; i_haddr = addr;
    i_req_full = 1'b0; i_rsp_empty = 1'b1;
    @(posedge clk); #1; cyc++;
    i_hsel = 1'b0; i_htrans = 2'b00; i_hwdata = wdata;
    for (int k = 0; k < 80; k++) begin
      drive_fifos(k, full_n);
      #4;
      if (o_rsp_rd_en) begin
        r_pops++;
        if (!i_rsp_empty) tmp = rsp_q.pop_front();
      end
      if (o_req_wr_en) begin
        r_pushes++;
        r_pkt = o_req_packet;
        if (!no_rsp) rsp_q.push_back('{rerr, rdat, cyc + 1 + delay});
      end
      if (o_hreadyout) begin
        r_ready_k = k; r_resp = o_hresp; r_err_pre = prev; r_rdata = o_hrdata; r_timeout = 1'b0;
      end
      prev = o_hresp;
      cyc++;
      @(posedge clk); #1;
      if (!r_timeout) break;
    end
    i_req_full = 1'b0; i_rsp_empty = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #5;
    checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b want 1", o_hreadyout); end
    checks++; if (o_hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", o_hresp); end
    checks++; if (o_hrdata !== '0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", o_hrdata); end
    checks++; if ({o_req_wr_en, o_rsp_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {o_req_wr_en, o_rsp_rd_en}); end
    checks++; if (o_req_packet !== '0) begin errors++; $display("FAIL reset_packet: got %h want 0", o_req_packet); end
    checks++; if ({o_source_sleep_ack, o_source_sleep_status} !== 2'b00) begin errors++; $display("FAIL reset_sleep: got %b want 00", {o_source_sleep_ack, o_source_sleep_status}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write;
    ahb_xfer(1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0, 0, 0, POSTED);
    checks++; if (r_pkt !== exp_pkt(1'b1, 32'h1000, 32'hDEADBEEF)) begin errors++; $display("FAIL write_pkt: got %h want %h", r_pkt, exp_pkt(1'b1, 32'h1000, 32'hDEADBEEF)); end
    checks++; if (r_pushes !== 1) begin errors++; $display("FAIL write_pushes: got %0d want 1", r_pushes); end
    checks++; if (r_resp !== 1'b0 || r_timeout) begin errors++; $display("FAIL write_resp: got %b timeout %b want 0", r_resp, r_timeout); end
    checks++; if (r_ready_k !== (POSTED ? 2 : 3)) begin errors++; $display("FAIL write_latency: got %0d want %0d", r_ready_k, POSTED ? 2 : 3); end
    if (POSTED) begin
      rsp_q.push_back('{1'b0, 32'h0, 0});
      idle_cycles(3);
    end
  endtask

  task automatic test_read;
    ahb_xfer(1'b0, 3'b010, 32'h2004, 32'hFFFFFFFF, 1'b0, 32'h12345678, 0, 0, 1'b0);
    checks++; if (r_rdata !== 32'h12345678) begin errors++; $display("FAIL read_data: got %h want 12345678", r_rdata); end
    checks++; if (r_resp !== 1'b0 || r_timeout) begin errors++; $display("FAIL read_resp: got %b timeout %b want 0", r_resp, r_timeout); end
    checks++; if (r_pkt !== exp_pkt(1'b0, 32'h2004, 32'h0)) begin errors++; $display("FAIL read_pkt: got %h want %h", r_pkt, exp_pkt(1'b0, 32'h2004, 32'h0)); end
    checks++; if (r_ready_k !== 3 || r_pops !== 1) begin errors++; $display("FAIL read_latency: got k=%0d pops=%0d want k=3 pops=1", r_ready_k, r_pops); end
  endtask

  task automatic test_full_hold;
    ahb_xfer(1'b0, 3'b010, 32'h2008, 32'h0, 1'b0, 32'hA5A5A5A5, 5, 0, 1'b0);
    checks++; if (r_pushes !== 1) begin errors++; $display("FAIL full_pushes: got %0d want 1", r_pushes); end
    checks++; if (r_ready_k !== 7) begin errors++; $display("FAIL full_hready: got ready at %0d want 7", r_ready_k); end
    checks++; if (r_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL full_data: got %h want a5a5a5a5", r_rdata); end
  endtask

  task automatic test_errors;
    ahb_xfer(1'b0, 3'b010, 32'h100C, 32'h0, 1'b1, 32'h0BAD0BAD, 0, 0, 1'b0);
    checks++; if ({r_err_pre, r_resp} !== 2'b11 || r_ready_k !== 4) begin errors++; $display("FAIL err_rsp: got pre=%b resp=%b k=%0d want 1 1 4", r_err_pre, r_resp, r_ready_k); end
    ahb_xfer(1'b1, 3'b000, 32'h1000, 32'h11, 1'b0, 32'h0, 0, 0, 1'b0);
    checks++; if ({r_err_pre, r_resp} !== 2'b11 || r_pushes !== 0) begin errors++; $display("FAIL err_size: got pre=%b resp=%b pushes=%0d want 1 1 0", r_err_pre, r_resp, r_pushes); end
    ahb_xfer(1'b0, 3'b010, 32'h1002, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0);
    checks++; if ({r_err_pre, r_resp} !== 2'b11 || r_pushes !== 0 || r_ready_k !== 1) begin errors++; $display("FAIL err_align: got pre=%b resp=%b pushes=%0d k=%0d want 1 1 0 1", r_err_pre, r_resp, r_pushes, r_ready_k); end
  endtask

  task automatic test_sleep;
    i_source_sleep_req = 1'b1; i_sink_sleep_status = 1'b1;
    @(posedge clk); #5;
    checks++; if ({o_source_sleep_ack, o_source_sleep_status} !== 2'b11) begin errors++; $display("FAIL sleep_enter: got %b want 11", {o_source_sleep_ack, o_source_sleep_status}); end
    @(posedge clk); #1;
    ahb_xfer(1'b1, 3'b010, 32'h3000, 32'h5, 1'b0, 32'h0, 0, 0, 1'b0);
    checks++; if (r_resp !== 1'b1 || r_pushes !== 0) begin errors++; $display("FAIL sleep_xfer: got resp=%b pushes=%0d want 1 0", r_resp, r_pushes); end
    #4;
    checks++; if (o_source_sleep_status !== 1'b1) begin errors++; $display("FAIL sleep_no_wake: got %b want 1", o_source_sleep_status); end
    i_source_sleep_req = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    checks++; if (o_source_sleep_status !== 1'b1) begin errors++; $display("FAIL sleep_sink_hold: got %b want 1", o_source_sleep_status); end
    i_sink_sleep_status = 1'b0;
    @(posedge clk); #5;
    checks++; if ({o_source_sleep_ack, o_source_sleep_status} !== 2'b00) begin errors++; $display("FAIL sleep_exit: got %b want 00", {o_source_sleep_ack, o_source_sleep_status}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    i_hsel = 1'b1; i_htrans = 2'b10; i_hwrite = 1'b0; i_hsize = 3'b010; i_haddr = 32'h4000;
    i_req_full = 1'b1;
    @(posedge clk); #1;
    i_hsel = 1'b0; i_htrans = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; i_req_full = 1'b0; i_rsp_empty = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    checks++; if ({o_req_wr_en, o_rsp_rd_en, o_hreadyout} !== 3'b001) begin errors++; $display("FAIL reset_mid: got wr/rd/rdy=%b want 001", {o_req_wr_en, o_rsp_rd_en, o_hreadyout}); end
    @(posedge clk); #5;
    checks++; if ({o_req_wr_en, o_rsp_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_mid_after: got %b want 00", {o_req_wr_en, o_rsp_rd_en}); end
    i_rsp_empty = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      logic wr, rerr, bad;
      logic [2:0] size;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd, rd;
      int f, d, exp_k;
      logic exp_resp;
      wr = 1'($urandom); rerr = ($urandom_range(0, 3) == 0);
      size = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom; rd = $urandom;
      f = $urandom_range(0, 3); d = $urandom_range(0, 3);
      bad = (size != 3'b010) || (addr[1:0] != 2'b00);
      if (bad) begin exp_k = 1; exp_resp = 1'b1; end
      else if (POSTED && wr) begin exp_k = ((f > 1) ? f : 1) + 1; exp_resp = 1'b0; end
      else begin exp_k = ((f > 1) ? f : 1) + 2 + d + int'(rerr); exp_resp = rerr; end
      ahb_xfer(wr, size, addr, wd, rerr, rd, f, d, POSTED && wr);
      checks++; if (r_resp !== exp_resp || r_ready_k !== exp_k) begin errors++; $display("FAIL rand%0d_resp: got resp=%b k=%0d want %b %0d", n, r_resp, r_ready_k, exp_resp, exp_k); end
      checks++; if (r_pushes !== (bad ? 0 : 1) || (!bad && r_pkt !== exp_pkt(wr, addr, wd))) begin errors++; $display("FAIL rand%0d_push: got n=%0d pkt=%h want n=%0d pkt=%h", n, r_pushes, r_pkt, bad ? 0 : 1, exp_pkt(wr, addr, wd)); end
      if (!bad && !wr && !rerr) begin
        checks++; if (r_rdata !== rd) begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", n, r_rdata, rd); end
      end
      if (exp_resp) begin
        checks++; if (r_err_pre !== 1'b1) begin errors++; $display("FAIL rand%0d_err1: got %b want 1", n, r_err_pre); end
      end
      if (!bad && POSTED && wr) begin
        rsp_q.push_back('{rerr, rd, 0});
        idle_cycles(3);
      end
    end
  endtask

`ifdef SRC_POSTED_WRITE_EN
  task automatic test_posted;
    for (int i = 0; i < 3; i++) begin
      ahb_xfer(1'b1, 3'b010, 32'h5000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0, 32'h0, 0, 0, 1'b1);
      checks++; if (r_resp !== 1'b0 || r_ready_k !== 2) begin errors++; $display("FAIL posted_w%0d: got resp=%b k=%0d want 0 2", i, r_resp, r_ready_k); end
    end
    for (int i = 0; i < 3; i++) rsp_q.push_back('{1'b0, 32'hBAD00000 + 32'(i), 0});
    ahb_xfer(1'b0, 3'b010, 32'h5010, 32'h0, 1'b0, 32'h600DF00D, 0, 0, 1'b0);
    checks++; if (r_pops !== 4 || rsp_q.size() !== 0) begin errors++; $display("FAIL posted_pops: got %0d left %0d want 4 0", r_pops, rsp_q.size()); end
    checks++; if (r_rdata !== 32'h600DF00D || r_resp !== 1'b0) begin errors++; $display("FAIL posted_read: got %h resp %b want 600df00d 0", r_rdata, r_resp); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; i_hsel = 1'b0; i_htrans = 2'b00; i_hwrite = 1'b0; i_hsize = 3'b010;
    i_haddr = '0; i_hwdata = '0; i_req_full = 1'b0; i_rsp_empty = 1'b1; i_rsp_packet = '0;
    i_source_sleep_req = 1'b0; i_sink_sleep_status = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_full_hold();
    test_errors();
    test_sleep();
    test_reset_mid();
    test_random();
`ifdef SRC_POSTED_WRITE_EN
    test_posted();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/source_controller.md
SOURCE_CONTROLLER -- requirements
Module: source_controller

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address bits; DATA_WIDTH, default 32, data bits; P_SIZE, default 3, outstanding-counter width.
REQ-002 SHALL have ports:
- i_clk_source  in  1  clock; one clock, all logic on its rising edge.
- i_rst_source  in  1  reset; synchronous, active-high.
- i_hsel  in  1  AHB slave select.
- i_htrans  in  2  AHB transfer type.
- i_hwrite  in  1  1 = write.
- i_hsize  in  3  transfer size.
- i_haddr  in  ADDR_WIDTH  address.
- i_hwdata  in  DATA_WIDTH  write data.
- o_hreadyout  out  1  slave ready.
- o_hresp  out  1  1 = ERROR.
- o_hrdata  out  DATA_WIDTH  read data.
- i_req_full  in  1  request FIFO full.
- o_req_wr_en  out  1  request push strobe.
- o_req_packet  out  ADDR_WIDTH+DATA_WIDTH+2  request packet.
- i_rsp_empty  in  1  response FIFO empty.
- i_rsp_packet  in  DATA_WIDTH+1  response packet.
- o_rsp_rd_en  out  1  response pop strobe.
- i_source_sleep_req  in  1  sleep request.
- o_source_sleep_ack  out  1  sleep acknowledge.
- o_source_sleep_status  out  1  controller is asleep.
- i_sink_sleep_status  in  1  far side is asleep.

Function
REQ-003 SHALL decode an address phase as i_hsel & i_htrans[1] & o_hreadyout; IDLE/BUSY are ignored and get a zero-wait OKAY.
REQ-004 SHALL use FSM states IDLE, DATA, PUSH, WAIT_RSP, ERR1, ERR2, SLEEP.
REQ-005 In IDLE, an accepted transfer SHALL register addr, write and size, then go to DATA with o_hreadyout=0.
REQ-006 A transfer with i_hsize!=3'b010, or with i_haddr[1:0]!=0, SHALL go to ERR1 and SHALL NOT be pushed.
REQ-007 DATA SHALL capture i_hwdata (writes) or 0 (reads) and go to PUSH.
REQ-008 Packet layout SHALL be: [MSB]=rd0_wr1, [MSB-1]=1'b1 valid marker, next ADDR_WIDTH bits=addr, low DATA_WIDTH bits=data.
REQ-009 PUSH SHALL assert o_req_wr_en for exactly one cycle, in the first cycle with i_req_full=0, then go to WAIT_RSP; while full it SHALL hold with o_req_wr_en=0.
REQ-010 WAIT_RSP SHALL pop on the first cycle with i_rsp_empty=0 (o_rsp_rd_en=1 for one cycle). It SHALL register i_rsp_packet[DATA_WIDTH-1:0] to o_hrdata.
REQ-011 If the popped i_rsp_packet[DATA_WIDTH] is 0, the controller SHALL return to IDLE with o_hreadyout=1 and o_hresp=0 for one cycle; if it is 1, the controller SHALL go to ERR1.
REQ-012 ERR1 SHALL drive o_hresp=1 with o_hreadyout=0; ERR2 SHALL drive o_hresp=1 with o_hreadyout=1, then go to IDLE.
REQ-013 Response packets are consumed strictly in order; the minimum read latency is address phase N, push N+2, and hreadyout one cycle after the pop.
REQ-014 If i_source_sleep_req=1 in IDLE with no accepted transfer and zero outstanding responses, the controller SHALL enter SLEEP. In SLEEP, o_source_sleep_ack=1 and o_source_sleep_status=1.
REQ-015 A transfer accepted in SLEEP SHALL get an ERROR response via ERR1/ERR2 and SHALL be neither pushed nor a cause of wake.
REQ-016 SLEEP SHALL exit to IDLE when i_source_sleep_req=0 and i_sink_sleep_status=0.

Reset
REQ-017 On reset the controller SHALL be in IDLE with o_hreadyout=1, o_hresp=0, o_hrdata=0, o_req_wr_en=0, o_req_packet=0, o_rsp_rd_en=0, both sleep outputs=0, and the outstanding counter=0.
REQ-018 Reset mid-transfer SHALL abandon the transfer without a push or pop on the following cycle.

Configuration
REQ-019 With SRC_POSTED_WRITE_EN defined, a write SHALL complete OKAY in the cycle after its push, and SHALL increment a P_SIZE-bit outstanding counter.
REQ-020 With SRC_POSTED_WRITE_EN defined, the controller SHALL pop and discard one response per count (decrement), in any state, and a read SHALL NOT complete until the counter is 0.
REQ-021 With SRC_POSTED_WRITE_EN defined, when the counter reaches 2**P_SIZE-1, a further write SHALL hold in PUSH.
REQ-022 Without SRC_POSTED_WRITE_EN, writes SHALL wait for their response exactly like reads, and the counter SHALL be constant 0.

Structure
REQ-023 The FSM state enum, packet field offsets and HSIZE_WORD SHALL live in the shared package bridge_pkg.
REQ-024 The block SHALL be a single module with no sub-module.

Verification
REQ-025 Write 0x1000 <= 0xDEADBEEF, response {0,0} -> packet {1,1,0x1000,0xDEADBEEF}, one OKAY cycle.
REQ-026 Read 0x2004, response {0,0x12345678} -> o_hrdata=0x12345678, o_hresp=0.
REQ-027 Read with i_req_full held high for 5 cycles -> no push and o_hreadyout=0 throughout; single push on release.
REQ-028 Response err bit=1 -> two-cycle ERROR (0/1 then 1/1); hsize=3'b000 or addr 0x1002 -> ERROR and no push.
REQ-029 Sleep request while idle -> ack and status go high; a transfer during sleep -> ERROR; release with i_sink_sleep_status=0 -> IDLE.
REQ-030 With SRC_POSTED_WRITE_EN, 3 writes then a read -> writes get zero response wait, and the read data is returned only after 3 discards.
